// File: rtl/matrix_mult_axil_core.sv
// Matrix multiply engine (C = A * B, N x N, signed elements) behind an AXI4-Lite slave.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock and synchronous active-high reset
//   S_AXI_AW* / W* / B*       : AXI4-Lite write address, data and response channels
//   S_AXI_AR* / R*            : AXI4-Lite read address and data channels
//   irq                       : level interrupt, STATUS.DONE and CTRL.IRQ_EN
// Map: 0x000 CTRL, 0x004 STATUS, 0x100 A, 0x200 B, 0x300 C (element (i,j) at +4*(i*N+j)).
// Only address bits [9:0] are decoded.
module matrix_mult_axil_core #(
  parameter int unsigned N                  = 4,
  parameter int unsigned ELEM_W             = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              irq
);

  localparam int unsigned DW    = 32;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned NE    = N * N;
  localparam int unsigned EW    = $clog2(NE);
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned PW    = 2 * ELEM_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_STORE} state_e;
  typedef enum logic [2:0] {RG_NONE, RG_CTRL, RG_STATUS, RG_A, RG_B, RG_C} region_e;

  state_e             state;
  logic [IW-1:0]      row, col, kk;
  logic [ACC_W-1:0]   acc;
  logic [ELEM_W-1:0]  a_mem [NE];
  logic [ELEM_W-1:0]  b_mem [NE];
  logic [ACC_W-1:0]   c_mem [NE];
  logic               done, irq_en;

  // Address decode shared by both channels; bits [1:0] are ignored.
  function automatic region_e decode(input logic [9:0] addr);
    logic [6:0] idx;
    region_e    r;
    idx = 7'(addr[7:2]);
    case (addr[9:8])
      2'd0:    r = (idx == 7'd0) ? RG_CTRL : ((idx == 7'd1) ? RG_STATUS : RG_NONE);
      2'd1:    r = (idx < 7'(NE)) ? RG_A : RG_NONE;
      2'd2:    r = (idx < 7'(NE)) ? RG_B : RG_NONE;
      default: r = (idx < 7'(NE)) ? RG_C : RG_NONE;
    endcase
    return r;
  endfunction

  // Byte-enable merge of a write into a stored element.
  function automatic logic [ELEM_W-1:0] merge(input logic [ELEM_W-1:0] old,
                                               input logic [DW-1:0] wd,
                                               input logic [3:0] strb);
    logic [DW-1:0] m;
    m = DW'(old);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = wd[8*b +: 8];
    end
    return m[ELEM_W-1:0];
  endfunction

  function automatic logic [DW-1:0] sext(input logic [ELEM_W-1:0] v);
    return {{(DW-ELEM_W){v[ELEM_W-1]}}, v};
  endfunction

  logic unused_bits_c;
  assign unused_bits_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Write-channel decode and control events
  region_e        aw_rg_c;
  logic [EW-1:0]  aw_idx_c;
  logic           aw_go_c, wr_fire_c, busy_c, start_c, finish_c;

  assign aw_rg_c   = decode(S_AXI_AWADDR[9:0]);
  assign aw_idx_c  = EW'(S_AXI_AWADDR[7:2]);
  assign aw_go_c   = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
  assign wr_fire_c = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign busy_c    = (state != ST_IDLE);
  assign start_c   = wr_fire_c && (aw_rg_c == RG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0] && !busy_c;
  assign finish_c  = (state == ST_STORE) && (row == IW'(N-1)) && (col == IW'(N-1));

  // Write channel: accept, store A/B, respond
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      for (int e = 0; e < int'(NE); e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else begin
      S_AXI_AWREADY <= aw_go_c;
      S_AXI_WREADY  <= aw_go_c;
      if (wr_fire_c) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (busy_c && (aw_rg_c == RG_A || aw_rg_c == RG_B)) ? RESP_SLVERR : RESP_OKAY;
        if (!busy_c && aw_rg_c == RG_A)
          a_mem[aw_idx_c] <= merge(a_mem[aw_idx_c], S_AXI_WDATA, S_AXI_WSTRB);
        if (!busy_c && aw_rg_c == RG_B)
          b_mem[aw_idx_c] <= merge(b_mem[aw_idx_c], S_AXI_WDATA, S_AXI_WSTRB);
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Control/status next values; engine completion beats a same-cycle software clear.
  logic done_d, irq_en_d;
  always_comb begin
    done_d   = done;
    irq_en_d = irq_en;
    if (wr_fire_c && aw_rg_c == RG_CTRL && S_AXI_WSTRB[0]) irq_en_d = S_AXI_WDATA[1];
    if (start_c) done_d = 1'b0;
    if (wr_fire_c && aw_rg_c == RG_STATUS && S_AXI_WDATA[1]) done_d = 1'b0;
    if (finish_c) done_d = 1'b1;
  end

  // irq registered from next values so it moves together with DONE
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      done   <= 1'b0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      done   <= done_d;
      irq_en <= irq_en_d;
      irq    <= done_d && irq_en_d;
    end
  end

  // Engine datapath operands
  logic [EW-1:0]             a_idx_c, b_idx_c, c_idx_c;
  logic signed [ELEM_W-1:0]  a_op_c, b_op_c;
  logic signed [PW-1:0]      prod_c;

  assign a_idx_c = EW'(32'(row) * N + 32'(kk));
  assign b_idx_c = EW'(32'(kk) * N + 32'(col));
  assign c_idx_c = EW'(32'(row) * N + 32'(col));
  assign a_op_c  = a_mem[a_idx_c];
  assign b_op_c  = b_mem[b_idx_c];
  assign prod_c  = PW'(a_op_c) * PW'(b_op_c);

  // Engine FSM: N MAC cycles then one STORE per C element, row-major
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
      kk    <= '0;
      acc   <= '0;
      for (int e = 0; e < int'(NE); e++) c_mem[e] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            state <= ST_MAC;
            row   <= '0;
            col   <= '0;
            kk    <= '0;
            acc   <= '0;
          end
        end
        ST_MAC: begin
          // 32-bit wrap of the running sum equals truncation of the exact sum
          acc <= acc + ACC_W'(prod_c);
          if (kk == IW'(N-1)) state <= ST_STORE;
          else                kk    <= kk + IW'(1);
        end
        ST_STORE: begin
          c_mem[c_idx_c] <= acc;
          acc <= '0;
          kk  <= '0;
          if (col == IW'(N-1)) begin
            col <= '0;
            if (row == IW'(N-1)) begin
              row   <= '0;
              state <= ST_IDLE;
            end else begin
              row   <= row + IW'(1);
              state <= ST_MAC;
            end
          end else begin
            col   <= col + IW'(1);
            state <= ST_MAC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data mux
  region_e        ar_rg_c;
  logic [EW-1:0]  ar_idx_c;
  logic [DW-1:0]  rd_data_c;
  logic [1:0]     rd_resp_c;

  assign ar_rg_c  = decode(S_AXI_ARADDR[9:0]);
  assign ar_idx_c = EW'(S_AXI_ARADDR[7:2]);

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (ar_rg_c)
      RG_CTRL:   rd_data_c = {30'd0, irq_en, 1'b0};
      RG_STATUS: rd_data_c = {30'd0, done, busy_c};
      RG_A:      rd_data_c = sext(a_mem[ar_idx_c]);
      RG_B:      rd_data_c = sext(b_mem[ar_idx_c]);
      RG_C: begin
        if (busy_c) rd_resp_c = RESP_SLVERR;
        else        rd_data_c = c_mem[ar_idx_c];
      end
      default: ;
    endcase
  end

  // Read channel: accept, capture, hold until RREADY
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data_c;
        S_AXI_RRESP  <= rd_resp_c;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_axil_core.sv
// Directed bench for matrix_mult_axil_core (N=4, ELEM_W=16).
module tb_matrix_mult_axil_core;

  localparam logic [9:0] CTRL   = 10'h000;
  localparam logic [9:0] STATUS = 10'h004;
  localparam int LAT = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_mult_axil_core dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .irq(irq)
  );

  function automatic logic [9:0] a_addr(input int i, input int j);
    return 10'(32'h100 + 4 * (i * 4 + j));
  endfunction
  function automatic logic [9:0] b_addr(input int i, input int j);
    return 10'(32'h200 + 4 * (i * 4 + j));
  endfunction
  function automatic logic [9:0] c_addr(input int i, input int j);
    return 10'(32'h300 + 4 * (i * 4 + j));
  endfunction

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    if (!awready) begin
      tests_run++; tests_failed++;
      $display("FAIL write_accept_timeout addr=%h", addr);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    if (!bvalid) begin
      tests_run++; tests_failed++;
      $display("FAIL write_resp_timeout addr=%h", addr);
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    if (!arready) begin
      tests_run++; tests_failed++;
      $display("FAIL read_accept_timeout addr=%h", addr);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    if (!rvalid) begin
      tests_run++; tests_failed++;
      $display("FAIL read_data_timeout addr=%h", addr);
    end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Cycles from the START capture edge until irq is first seen; -1 on timeout.
  task automatic wait_done(input int cap, output int lat);
    lat = -1;
    while (cyc - cap < 300) begin
      @(negedge clk);
      if (irq) begin lat = cyc - cap; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    rst = 1'b1;
    awaddr = CTRL; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (awready !== 1'b0) begin tests_failed++; $display("FAIL reset_no_accept got %b expected 0", awready); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({awready, wready, bvalid, arready, rvalid, irq, bresp, rresp} !== 10'd0 || rdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b rdata %h expected all 0",
               {awready, wready, bvalid, arready, rvalid, irq, bresp, rresp}, rdata);
    end
    axi_read(CTRL, d, r);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_ctrl got %h expected 0", d); end
    axi_read(STATUS, d, r);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_status got %h expected 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int cap, lat;
    logic [31:0] exp_c [4];
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    axi_write(a_addr(0,0), 32'd1, 4'hF, r); axi_write(a_addr(0,1), 32'd2, 4'hF, r);
    axi_write(a_addr(1,0), 32'd3, 4'hF, r); axi_write(a_addr(1,1), 32'd4, 4'hF, r);
    axi_write(b_addr(0,0), 32'd5, 4'hF, r); axi_write(b_addr(0,1), 32'd6, 4'hF, r);
    axi_write(b_addr(1,0), 32'd7, 4'hF, r); axi_write(b_addr(1,1), 32'd8, 4'hF, r);
    axi_write(CTRL, 32'h2, 4'hF, r);
    axi_write(CTRL, 32'h3, 4'hF, r);
    cap = cyc - 1;
    wait_done(cap, lat);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("FAIL basic_latency got %0d expected %0d", lat, LAT); end
    for (int n = 0; n < 4; n++) begin
      axi_read(c_addr(n / 2, n % 2), d, r);
      tests_run++;
      if (d !== exp_c[n] || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL basic_c%0d got %h/%b expected %h/00", n, d, r, exp_c[n]);
      end
    end
    axi_read(c_addr(2,2), d, r);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL basic_c22 got %h expected 0", d); end
    axi_read(STATUS, d, r);
    tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL basic_status got %h expected 2", d); end
  endtask

  task automatic test_signed();
    logic [31:0] d; logic [1:0] r; int cap, lat;
    logic [31:0] exp_c [4];
    exp_c = '{32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFB, 32'hFFFFFFFA};
    axi_write(a_addr(0,0), 32'hFFFF, 4'hF, r); axi_write(a_addr(0,1), 32'h0, 4'hF, r);
    axi_write(a_addr(1,0), 32'h0, 4'hF, r);    axi_write(a_addr(1,1), 32'hFFFF, 4'hF, r);
    axi_write(b_addr(0,0), 32'h3, 4'hF, r);    axi_write(b_addr(0,1), 32'hFFFC, 4'hF, r);
    axi_write(b_addr(1,0), 32'h5, 4'hF, r);    axi_write(b_addr(1,1), 32'h6, 4'hF, r);
    axi_write(a_addr(2,2), 32'h7FFF, 4'hF, r); axi_write(b_addr(2,2), 32'h7FFF, 4'hF, r);
    axi_write(a_addr(3,3), 32'h7, 4'hF, r);    axi_write(b_addr(3,3), 32'hFFFE, 4'hF, r);
    axi_write(STATUS, 32'h2, 4'hF, r);
    axi_write(CTRL, 32'h3, 4'hF, r);
    cap = cyc - 1;
    wait_done(cap, lat);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("FAIL signed_latency got %0d expected %0d", lat, LAT); end
    for (int n = 0; n < 4; n++) begin
      axi_read(c_addr(n / 2, n % 2), d, r);
      tests_run++;
      if (d !== exp_c[n] || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL signed_c%0d got %h/%b expected %h/00", n, d, r, exp_c[n]);
      end
    end
    axi_read(c_addr(2,2), d, r);
    tests_run++;
    if (d !== 32'h3FFF0001) begin tests_failed++; $display("FAIL signed_c22 got %h expected 3fff0001", d); end
    axi_read(c_addr(3,3), d, r);
    tests_run++;
    if (d !== 32'hFFFFFFF2) begin tests_failed++; $display("FAIL signed_c33 got %h expected fffffff2", d); end
    axi_read(a_addr(0,0), d, r);
    tests_run++;
    if (d !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL signed_a00 got %h expected ffffffff", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_high got %b expected 1", irq); end
    axi_write(CTRL, 32'h0, 4'hF, r);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_en_off got %b expected 0", irq); end
    axi_write(CTRL, 32'h2, 4'hF, r);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_en_on got %b expected 1", irq); end
    axi_write(STATUS, 32'h2, 4'hF, r);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_clear got %b expected 0", irq); end
    axi_read(STATUS, d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL irq_status got %h expected 0", d); end
    axi_read(CTRL, d, r);
    tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL irq_ctrl got %h expected 2", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r;
    axi_write(a_addr(0,1), 32'h1234ABCD, 4'b0001, r);
    axi_read(a_addr(0,1), d, r);
    tests_run++;
    if (d !== 32'h000000CD) begin tests_failed++; $display("FAIL strobe_low got %h expected 000000cd", d); end
    axi_write(a_addr(0,1), 32'h00008000, 4'b0010, r);
    axi_read(a_addr(0,1), d, r);
    tests_run++;
    if (d !== 32'hFFFF80CD) begin tests_failed++; $display("FAIL strobe_high got %h expected ffff80cd", d); end
    axi_write(CTRL, 32'h3, 4'b0010, r);
    axi_read(STATUS, d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL strobe_start got %h expected 0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r;
    axi_write(10'h140, 32'h55, 4'hF, r);
    tests_run++;
    if (r !== 2'b00) begin tests_failed++; $display("FAIL unmapped_bresp got %b expected 00", r); end
    axi_read(10'h140, d, r);
    tests_run++;
    if (d !== 32'd0 || r !== 2'b00) begin tests_failed++; $display("FAIL unmapped_read got %h/%b expected 0/00", d, r); end
    axi_read(10'h008, d, r);
    tests_run++;
    if (d !== 32'd0 || r !== 2'b00) begin tests_failed++; $display("FAIL unmapped_reg got %h/%b expected 0/00", d, r); end
    axi_write(c_addr(0,0), 32'h1111, 4'hF, r);
    axi_read(c_addr(0,0), d, r);
    tests_run++;
    if (d !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL c_readonly got %h expected fffffffd", d); end
  endtask

  task automatic test_busy();
    logic [31:0] d; logic [1:0] r; int cap, lat;
    axi_write(CTRL, 32'h3, 4'hF, r);
    cap = cyc - 1;
    axi_write(a_addr(0,0), 32'h55, 4'hF, r);
    tests_run++;
    if (r !== 2'b10) begin tests_failed++; $display("FAIL busy_bresp got %b expected 10", r); end
    axi_read(c_addr(0,0), d, r);
    tests_run++;
    if (d !== 32'd0 || r !== 2'b10) begin tests_failed++; $display("FAIL busy_cread got %h/%b expected 0/10", d, r); end
    axi_read(STATUS, d, r);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL busy_status got %h expected 1", d); end
    axi_write(CTRL, 32'h3, 4'hF, r);
    wait_done(cap, lat);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("FAIL busy_latency got %0d expected %0d", lat, LAT); end
    axi_read(a_addr(0,0), d, r);
    tests_run++;
    if (d !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL busy_a00 got %h expected ffffffff", d); end
  endtask

  task automatic test_handshake();
    logic ok; int n;
    // read response stall
    araddr = a_addr(0,0); arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = CTRL;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!rvalid || rdata !== 32'hFFFFFFFF || rresp !== 2'b00 || arready) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL read_stall got rvalid %b rdata %h arready %b expected 1/ffffffff/0", rvalid, rdata, arready); end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rvalid !== 1'b0) begin tests_failed++; $display("FAIL read_release got %b expected 0", rvalid); end
    // write response stall
    awaddr = 10'h3F0; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    @(posedge clk); #1;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!bvalid || bresp !== 2'b00 || awready || wready) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL write_stall got bvalid %b bresp %b awready %b expected 1/00/0", bvalid, bresp, awready); end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    // address without data
    awvalid = 1'b1; wvalid = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (awready || bvalid) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL aw_without_w got awready %b expected 0", awready); end
    awvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int cap; int bad;
    axi_write(CTRL, 32'h3, 4'hF, r);
    cap = cyc - 1;
    while (cyc < cap + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL midreset_irq got %b expected 0", irq); end
    axi_read(STATUS, d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL midreset_status got %h expected 0", d); end
    axi_read(a_addr(0,0), d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL midreset_a00 got %h expected 0", d); end
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      axi_read(c_addr(n / 4, n % 4), d, r);
      if (d !== 32'd0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL midreset_c got %0d nonzero elements expected 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    test_reset();
    test_basic();
    test_signed();
    test_irq();
    test_strobe();
    test_unmapped();
    test_busy();
    test_handshake();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_mult_axil_core.md
MATRIX_MULT_AXIL_CORE -- requirements
Module: matrix_mult_axil_core

Interface
REQ-001 Parameter N, default 4, matrix dimension, legal 2..8.
REQ-002 Parameter ELEM_W, default 16, signed element width of A and B, legal 4..16.
REQ-003 Parameter C_S_AXI_DATA_WIDTH, default 32, bus width, fixed at 32.
REQ-004 Parameter C_S_AXI_ADDR_WIDTH, default 10, byte address width.
REQ-005 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: standard AXI4-Lite write channels, widths per parameters.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels.
REQ-009 irq  out  1  level interrupt = STATUS.DONE AND CTRL.IRQ_EN.

Function
REQ-010 Address map (byte): 0x000 CTRL, 0x004 STATUS, 0x100 A bank, 0x200 B bank, 0x300 C bank; element (i,j) at bank + 4*(i*N+j); indices >= N*N unmapped.
REQ-011 CTRL: bit0 START write-1 pulse (reads 0), bit1 IRQ_EN read/write; other bits read 0.
REQ-012 STATUS (read): bit0 BUSY, bit1 DONE sticky; writing 1 to bit1 clears DONE; other bits ignored.
REQ-013 A/B writes store WDATA[ELEM_W-1:0]; reads return the value sign-extended to 32 bits.
REQ-014 C elements are 32-bit, result = sum over k of A(i,k)*B(k,j), computed at full precision then truncated to low 32 bits; C is read-only.
REQ-015 Write accept: AWREADY and WREADY asserted together for one cycle only when AWVALID, WVALID both high and BVALID low; BVALID rises the next cycle and holds until BREADY.
REQ-016 WSTRB byte-enables apply to CTRL, A, B; START takes effect only if WSTRB[0] is set.
REQ-017 Read accept: ARREADY one cycle when ARVALID high and RVALID low; RDATA/RRESP valid next cycle, held stable until RREADY.
REQ-018 Read and write channels independent; one outstanding transaction per channel.
REQ-019 Unmapped addresses: write ignored, read returns 0, response OKAY (2'b00).
REQ-020 While BUSY, writes to A/B are dropped with BRESP SLVERR (2'b10); reads of C return 0 with RRESP SLVERR; CTRL/STATUS unaffected.
REQ-021 Engine FSM: IDLE, MAC, STORE. START in IDLE -> MAC with i=j=k=0, accumulator cleared, DONE cleared, BUSY set.
REQ-022 MAC: one multiply-accumulate per cycle; after k=N-1 -> STORE.
REQ-023 STORE: write accumulator to C(i,j), clear accumulator, advance j then i (row-major); if (i,j)=(N-1,N-1) -> IDLE with BUSY=0, DONE=1 in same edge, else -> MAC with k=0.
REQ-024 Latency: DONE visible exactly N*N*(N+1) cycles after the cycle START is written (N=4: 80).
REQ-025 START while BUSY is ignored; IRQ_EN write while BUSY takes effect.
REQ-026 DONE clear by software in same cycle as engine sets DONE: set wins.
REQ-027 A, B, C contents persist across operations; C holds prior result until overwritten element by element.

Reset
REQ-028 On S_AXI_ARESET high at a clock edge: FSM to IDLE, BUSY=0, DONE=0, IRQ_EN=0, irq=0, all AXI READY/VALID outputs 0, BRESP/RRESP/RDATA 0, counters and accumulator 0.
REQ-029 A, B, C banks clear to 0 on reset; reset mid-operation aborts without completing C.
REQ-030 First transaction accepted no earlier than the cycle after reset deasserts.

Verification
REQ-031 N=2: A=[1,2;3,4], B=[5,6;7,8], START -> DONE after 12 cycles; C reads 19,22,43,50, RRESP OKAY.
REQ-032 Signed: N=2, ELEM_W=16, A=[-1,0;0,-1] (0xFFFF), B=[3,-4;5,6] -> C reads 0xFFFFFFFD,0x00000004,0xFFFFFFFB,0xFFFFFFFA; A(0,0) reads 0xFFFFFFFF.
REQ-033 IRQ: IRQ_EN=1, START -> irq rises with DONE; write STATUS=0x2 -> irq and DONE low next cycle.
REQ-034 Busy protection: write A(0,0) during BUSY -> BRESP 2'b10, A unchanged; read C during BUSY -> RDATA 0, RRESP 2'b10; second START ignored, DONE timing unchanged.
REQ-035 Handshake: hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stable, no new AW/AR accepted; AWVALID without WVALID -> no AWREADY.
REQ-036 Reset mid-MAC (cycle 5 of N=4 run) -> BUSY=0, DONE=0, all C read 0.
